// File: rtl/ext_regfile.sv
// ext_regfile: DEPTH x WIDTH register file with RISC-V load-extend write path; define EXT_REGFILE_BYPASS_EN for write-to-read forwarding
module ext_regfile #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [2:0]        wmode,
    input  logic [1:0]        wbyte_off,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [WIDTH-1:0]  rdata1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [WIDTH-1:0]  rdata2
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] ext;
    logic [7:0]       b;
    logic [15:0]      h;
    logic             wok, rok1, rok2, fwd1, fwd2;
    // lane select and sign/zero extension of the write data; undefined modes fall through to LW
    always_comb begin
        b   = wdata[8*wbyte_off +: 8];
        h   = wdata[16*wbyte_off[1] +: 16];
        ext = wmode == 3'b000 ? {{(WIDTH-8){b[7]}}, b} :
              wmode == 3'b001 ? {{(WIDTH-16){h[15]}}, h} :
              wmode == 3'b100 ? {{(WIDTH-8){1'b0}}, b} :
              wmode == 3'b101 ? {{(WIDTH-16){1'b0}}, h} :
                                WIDTH'(wdata[31:0]);
    end
    // only the addressed, writable entry takes the extended value
    always_comb begin
        for (int i = 0; i < DEPTH; i++) mem_d[i] = (we && wok && int'(waddr) == i) ? ext : mem_q[i];
    end
    // storage with synchronous clear; reset wins over a coincident write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end
    // out-of-range and hardwired-zero addresses are never written and read as 0
    always_comb begin
        wok  = int'(waddr) < DEPTH && !(ZERO_REG != 0 && waddr == '0);
        rok1 = int'(raddr1) < DEPTH && !(ZERO_REG != 0 && raddr1 == '0);
        rok2 = int'(raddr2) < DEPTH && !(ZERO_REG != 0 && raddr2 == '0);
`ifdef EXT_REGFILE_BYPASS_EN
        fwd1 = we && !rst && wok && raddr1 == waddr;
        fwd2 = we && !rst && wok && raddr2 == waddr;
`else
        fwd1 = 1'b0;
        fwd2 = 1'b0;
`endif
        rdata1 = fwd1 ? ext : rok1 ? mem_q[raddr1] : '0;
        rdata2 = fwd2 ? ext : rok2 ? mem_q[raddr2] : '0;
    end
endmodule
